// File: rtl/r2r_wave_gen.sv
// r2r_wave_gen: sample source for an 8-bit R2R DAC ladder.
// A programmable divider advances an 8-bit phase. The phase is shaped into a
// sawtooth, triangle or square wave and then amplitude scaled. Mode 0 instead
// samples ext_data and holds it at the divided rate. dac_code bit 7 is the MSB.
module r2r_wave_gen #(
  parameter int                   DIV_WIDTH   = 16,
  parameter logic [DIV_WIDTH-1:0] DEFAULT_DIV = DIV_WIDTH'(99)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic       cfg_wr,
  input  logic [1:0] cfg_addr,
  input  logic [7:0] cfg_data,
  input  logic [7:0] ext_data,
  output logic [7:0] dac_code,
  output logic       tick,
  output logic       wrap
);

  localparam logic [1:0] ADDR_MODE  = 2'd0;
  localparam logic [1:0] ADDR_DIVLO = 2'd1;
  localparam logic [1:0] ADDR_DIVHI = 2'd2;
  localparam logic [1:0] ADDR_AMP   = 2'd3;

  localparam logic [1:0] MODE_EXT = 2'd0;
  localparam logic [1:0] MODE_SAW = 2'd1;
  localparam logic [1:0] MODE_TRI = 2'd2;
  localparam logic [1:0] MODE_SQR = 2'd3;

  // configuration registers
  logic [1:0]           r_mode;
  logic [DIV_WIDTH-1:0] r_div;
  logic [7:0]           r_amp;

  // run state
  logic [DIV_WIDTH-1:0] r_cnt;
  logic [7:0]           r_phase;
  logic [7:0]           r_dac;
  logic                 r_tick;
  logic                 r_wrap;

  logic                 w_mode_wr;
  logic                 w_strobe;
  logic [7:0]           w_wave;
  logic [8:0]           w_amp_p1;
  logic [16:0]          w_prod;
  logic [7:0]           w_scaled;
  logic [7:0]           w_code;
  logic [DIV_WIDTH-1:0] w_div_next;

  assign w_mode_wr = cfg_wr && (cfg_addr == ADDR_MODE);

  // Divider compare is >= so shrinking div below the running count fires at once.
  assign w_strobe  = ena && (r_cnt >= r_div);

  // Waveform shaping from the current (pre-increment) phase
  always_comb begin
    w_wave = r_phase;
    case (r_mode)
      MODE_EXT: w_wave = ext_data;
      MODE_SAW: w_wave = r_phase;
      MODE_TRI: w_wave = r_phase[7] ? ~{r_phase[6:0], 1'b0} : {r_phase[6:0], 1'b0};
      MODE_SQR: w_wave = r_phase[7] ? 8'hFF : 8'h00;
      default:  w_wave = r_phase;
    endcase
  end

  // Amplitude scaling: (w * (amp+1)) >> 8, so amp=255 is unity and amp=0 is silence.
  assign w_amp_p1 = {1'b0, r_amp} + 9'd1;
  assign w_prod   = 17'(w_wave) * 17'(w_amp_p1);
  assign w_scaled = 8'(w_prod >> 8);

  // External samples bypass scaling entirely
  assign w_code   = (r_mode == MODE_EXT) ? ext_data : w_scaled;

  // Byte-lane update of the divider register for the two div addresses
  always_comb begin
    w_div_next = r_div;
    if (cfg_wr && cfg_addr == ADDR_DIVLO)
      w_div_next[7:0] = cfg_data;
    if (cfg_wr && cfg_addr == ADDR_DIVHI && DIV_WIDTH > 8)
      w_div_next = DIV_WIDTH'({cfg_data, r_div[7:0]});
  end

  // Configuration register writes, independent of ena
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode <= MODE_SAW;
      r_div  <= DEFAULT_DIV;
      r_amp  <= 8'hFF;
    end else if (cfg_wr) begin
      r_div <= w_div_next;
      if (cfg_addr == ADDR_MODE) r_mode <= cfg_data[1:0];
      if (cfg_addr == ADDR_AMP)  r_amp  <= cfg_data;
    end
  end

  // Divider, phase and output sample; a mode write restarts the waveform and
  // takes priority over a coincident strobe (dac_code keeps its last value).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_phase <= 8'd0;
      r_dac   <= 8'd0;
      r_tick  <= 1'b0;
      r_wrap  <= 1'b0;
    end else if (w_mode_wr) begin
      r_cnt   <= '0;
      r_phase <= 8'd0;
      r_tick  <= 1'b0;
      r_wrap  <= 1'b0;
    end else if (w_strobe) begin
      r_cnt   <= '0;
      r_phase <= r_phase + 8'd1;
      r_dac   <= w_code;
      r_tick  <= 1'b1;
      r_wrap  <= (r_phase == 8'hFF);
    end else begin
      if (ena) r_cnt <= r_cnt + DIV_WIDTH'(1);
      r_tick <= 1'b0;
      r_wrap <= 1'b0;
    end
  end

  assign dac_code = r_dac;
  assign tick     = r_tick;
  assign wrap     = r_wrap;

endmodule

// File: tb/tb_r2r_wave_gen.sv
// Directed bench for r2r_wave_gen: a table of waveform/scaling points plus
// hand-written sequences for divider timing, ena hold, mode-write priority,
// external sample-and-hold, shrinking div and reset-over-write.
module tb_r2r_wave_gen;

  logic       clk = 1'b0;
  logic       rst, ena, cfg_wr;
  logic [1:0] cfg_addr;
  logic [7:0] cfg_data, ext_data;
  logic [7:0] dac_code;
  logic       tick, wrap;

  int checks = 0;
  int fails  = 0;

  r2r_wave_gen dut (
    .clk(clk), .rst(rst), .ena(ena), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .ext_data(ext_data), .dac_code(dac_code),
    .tick(tick), .wrap(wrap)
  );

  always #50 clk = ~clk;

  typedef struct {
    logic [1:0] mode;
    logic [7:0] amp;
    int         phase;
    logic [7:0] exp_dac;
  } vec_t;

  vec_t vecs [16];

  // one clock; inputs change and outputs are sampled 1 time unit after the edge
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    cfg_wr = 1'b1; cfg_addr = a; cfg_data = d;
    cyc();
    cfg_wr = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; ena = 1'b0; cfg_wr = 1'b0;
    cyc();
    rst = 1'b0;
  endtask

  task automatic setup(input logic [15:0] div, input logic [7:0] amp, input logic [1:0] mode);
    do_reset();
    wr(2'd1, div[7:0]);
    wr(2'd2, div[15:8]);
    wr(2'd3, amp);
    wr(2'd0, {6'd0, mode});
  endtask

  initial begin
    vecs[0]  = '{2'd1, 8'hFF,   0, 8'd0};
    vecs[1]  = '{2'd1, 8'hFF, 200, 8'd200};
    vecs[2]  = '{2'd1, 8'h7F, 255, 8'd127};
    vecs[3]  = '{2'd1, 8'h00, 255, 8'd0};
    vecs[4]  = '{2'd1, 8'h7F, 100, 8'd50};
    vecs[5]  = '{2'd2, 8'hFF,   0, 8'd0};
    vecs[6]  = '{2'd2, 8'hFF, 127, 8'd254};
    vecs[7]  = '{2'd2, 8'hFF, 128, 8'd255};
    vecs[8]  = '{2'd2, 8'hFF, 255, 8'd1};
    vecs[9]  = '{2'd2, 8'hFF, 200, 8'd111};
    vecs[10] = '{2'd2, 8'h3F,  64, 8'd32};
    vecs[11] = '{2'd3, 8'hFF, 127, 8'd0};
    vecs[12] = '{2'd3, 8'hFF, 128, 8'd255};
    vecs[13] = '{2'd3, 8'h7F, 200, 8'd127};
    vecs[14] = '{2'd3, 8'h00, 200, 8'd0};
    vecs[15] = '{2'd1, 8'hFF,  37, 8'd37};

    rst = 1'b0; ena = 1'b0; cfg_wr = 1'b0; cfg_addr = 2'd0;
    cfg_data = 8'd0; ext_data = 8'd0;
    #1;

    // reset state
    do_reset();
    check("rst_dac", dac_code, 0);
    check("rst_tick", tick, 0);
    check("rst_wrap", wrap, 0);

    // full saw sweep at div=0: one code per cycle, wrap on the 255->0 tick
    setup(16'd0, 8'hFF, 2'd1);
    ena = 1'b1;
    for (int i = 0; i < 257; i++) begin
      cyc();
      check("saw_dac", dac_code, i & 255);
      check("saw_tick", tick, 1);
      check("saw_wrap", wrap, (i == 255) ? 1 : 0);
    end
    // mode write coincident with a strobe: no tick, dac holds, then restart
    wr(2'd0, 8'd1);
    check("modewr_tick", tick, 0);
    check("modewr_dac", dac_code, 0);
    cyc();
    check("modewr_dac2", dac_code, 0);
    check("modewr_tick2", tick, 1);
    cyc();
    check("modewr_dac3", dac_code, 1);
    ena = 1'b0;

    // div=3: tick every 4th cycle
    setup(16'd3, 8'hFF, 2'd1);
    ena = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cyc();
      check("div3_tick", tick, (i % 4 == 3) ? 1 : 0);
    end
    check("div3_dac", dac_code, 2);
    cyc(); cyc();
    // freeze mid-period
    ena = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      check("hold_tick", tick, 0);
      check("hold_dac", dac_code, 2);
    end
    ena = 1'b1;
    cyc();
    check("resume_tick0", tick, 0);
    cyc();
    check("resume_tick1", tick, 1);
    check("resume_dac", dac_code, 3);
    ena = 1'b0;

    // triangle sweep
    setup(16'd0, 8'hFF, 2'd2);
    ena = 1'b1;
    for (int i = 0; i < 256; i++) begin
      cyc();
      check("tri_dac", dac_code, (i < 128) ? 2 * i : 255 - 2 * (i - 128));
    end
    ena = 1'b0;

    // square sweep
    setup(16'd0, 8'hFF, 2'd3);
    ena = 1'b1;
    for (int i = 0; i < 256; i++) begin
      cyc();
      check("sqr_dac", dac_code, (i < 128) ? 0 : 255);
    end
    ena = 1'b0;

    // table: waveform + scaling at selected phases
    foreach (vecs[k]) begin
      setup(16'd0, vecs[k].amp, vecs[k].mode);
      ena = 1'b1;
      repeat (vecs[k].phase + 1) cyc();
      ena = 1'b0;
      check($sformatf("vec%0d_dac", k), dac_code, vecs[k].exp_dac);
    end

    // mode 0: sample-and-hold every 10th cycle, amp ignored
    begin
      int exp_d;
      exp_d = 0;
      setup(16'd9, 8'h10, 2'd0);
      ena = 1'b1;
      for (int i = 0; i < 40; i++) begin
        ext_data = 8'(i + 5);
        cyc();
        if (i % 10 == 9) exp_d = i + 5;
        check("ext_tick", tick, (i % 10 == 9) ? 1 : 0);
        check("ext_dac", dac_code, exp_d);
      end
      ena = 1'b0;
    end

    // shrink div below the running count -> tick next cycle
    setup(16'd100, 8'hFF, 2'd1);
    ena = 1'b1;
    repeat (50) cyc();
    check("cnt50_tick", tick, 0);
    wr(2'd1, 8'd20);
    check("shrink_tick0", tick, 0);
    cyc();
    check("shrink_tick1", tick, 1);
    check("shrink_dac", dac_code, 0);
    cyc();
    check("shrink_tick2", tick, 0);

    // reset with concurrent mode write: reset wins (saw, div=99, amp=FF)
    rst = 1'b1; ena = 1'b1; cfg_wr = 1'b1; cfg_addr = 2'd0; cfg_data = 8'd2;
    cyc();
    rst = 1'b0; cfg_wr = 1'b0;
    check("rstwr_dac", dac_code, 0);
    check("rstwr_tick", tick, 0);
    check("rstwr_wrap", wrap, 0);
    for (int i = 0; i < 200; i++) begin
      cyc();
      check("defdiv_tick", tick, (i == 99 || i == 199) ? 1 : 0);
      if (i == 199) check("defmode_dac", dac_code, 1);
    end
    ena = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
